pp_cmd_issue: RTL

- Upstream issue stage for the pp compute core.
- Accepts (cmd, in1, in2) operation requests from the host-side stream and buffers them in a small FIFO.
- Issues one request at a time to the core's enable/cmd/in1/in2 inputs and waits for the core's valid.
- Returns the core's result, plus a timeout flag, on a valid/ready output stream.

---
 rtl/pp_cmd_issue.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/pp_cmd_issue.sv
// pp_cmd_issue: upstream issue stage for the pp compute core.
// Buffers (cmd, in1, in2) requests in a small FIFO, issues them one at a
// time to the core, waits for the core's valid (or a timeout) and returns
// the result on a valid/ready stream.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   s_valid/s_ready     request stream handshake
//   s_cmd, s_in1, s_in2 request payload
//   enable              one-cycle core start strobe
//   cmd, in1, in2       operands to the core, held from issue until next issue
//   core_valid          core result valid (honoured only while waiting)
//   core_result         core result data
//   m_valid/m_ready     result stream handshake
//   m_result            captured result (0 on timeout)
//   m_timeout           result was aborted by timeout
//   busy                FSM active or FIFO not empty
//   issued_cnt          wrapping count of requests issued to the core
module pp_cmd_issue #(
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned CMD_SIZE_LOG2 = 3,
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned TIMEOUT       = 255
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            s_valid,
   output logic                            s_ready,
   input  logic [(1<<CMD_SIZE_LOG2)-1:0]   s_cmd,
   input  logic [DATA_W-1:0]               s_in1,
   input  logic [DATA_W-1:0]               s_in2,
   output logic                            enable,
   output logic [(1<<CMD_SIZE_LOG2)-1:0]   cmd,
   output logic [DATA_W-1:0]               in1,
   output logic [DATA_W-1:0]               in2,
   input  logic                            core_valid,
   input  logic [DATA_W-1:0]               core_result,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic [DATA_W-1:0]               m_result,
   output logic                            m_timeout,
   output logic                            busy,
   output logic [15:0]                     issued_cnt
);

   localparam int unsigned CMD_W = 1 << CMD_SIZE_LOG2;
   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned CW    = AW + 1;
   localparam int unsigned ENT_W = CMD_W + 2 * DATA_W;
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_HOLD  = 2'd3
   } state_e;

   state_e              state_q;
   logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr_q;
   logic [AW-1:0]       rd_ptr_q;
   logic [CW-1:0]       cnt_q;
   logic [CW-1:0]       cnt_d;
   logic                s_ready_q;
   logic                busy_q;
   logic                enable_q;
   logic [CMD_W-1:0]    cmd_q;
   logic [DATA_W-1:0]   in1_q;
   logic [DATA_W-1:0]   in2_q;
   logic                m_valid_q;
   logic [DATA_W-1:0]   m_result_q;
   logic                m_timeout_q;
   logic [15:0]         issued_q;
   logic [15:0]         tmo_q;

   logic                fifo_empty;
   logic                push;
   logic                pop;
   logic                idle_nx;
   logic [ENT_W-1:0]    head;

   assign fifo_empty = (cnt_q == '0);
   assign push       = s_valid && s_ready_q;
   // The FIFO head is consumed when IDLE starts an issue or HOLD hands off
   // its result and chains straight into the next issue.
   assign pop        = !fifo_empty &&
                       ((state_q == S_IDLE) || ((state_q == S_HOLD) && m_ready));
   assign idle_nx    = fifo_empty &&
                       ((state_q == S_IDLE) || ((state_q == S_HOLD) && m_ready));
   assign head       = mem_q[rd_ptr_q];

   // Next occupancy, used to keep s_ready and busy registered yet current.
   always_comb begin
      cnt_d = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // FIFO storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {s_cmd, s_in1, s_in2};
      end
   end

   // FIFO pointers, handshake flags and the issue FSM.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         s_ready_q   <= 1'b0;
         busy_q      <= 1'b0;
         enable_q    <= 1'b0;
         cmd_q       <= '0;
         in1_q       <= '0;
         in2_q       <= '0;
         m_valid_q   <= 1'b0;
         m_result_q  <= '0;
         m_timeout_q <= 1'b0;
         issued_q    <= '0;
         tmo_q       <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         cnt_q     <= cnt_d;
         s_ready_q <= (cnt_d != CW'(FIFO_DEPTH));
         busy_q    <= !idle_nx || (cnt_d != '0);
         enable_q  <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (!fifo_empty) begin
                  cmd_q    <= head[ENT_W-1 -: CMD_W];
                  in1_q    <= head[2*DATA_W-1 -: DATA_W];
                  in2_q    <= head[DATA_W-1:0];
                  enable_q <= 1'b1;
                  state_q  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               issued_q <= issued_q + 16'd1;
               tmo_q    <= '0;
               state_q  <= S_WAIT;
            end
            S_WAIT: begin
               // A result arriving on the last allowed cycle beats the timeout.
               if (core_valid) begin
                  m_result_q  <= core_result;
                  m_timeout_q <= 1'b0;
                  m_valid_q   <= 1'b1;
                  state_q     <= S_HOLD;
               end else if (tmo_q == TMO_LAST) begin
                  m_result_q  <= '0;
                  m_timeout_q <= 1'b1;
                  m_valid_q   <= 1'b1;
                  state_q     <= S_HOLD;
               end else begin
                  tmo_q <= tmo_q + 16'd1;
               end
            end
            S_HOLD: begin
               if (m_ready) begin
                  m_valid_q <= 1'b0;
                  if (!fifo_empty) begin
                     cmd_q    <= head[ENT_W-1 -: CMD_W];
                     in1_q    <= head[2*DATA_W-1 -: DATA_W];
                     in2_q    <= head[DATA_W-1:0];
                     enable_q <= 1'b1;
                     state_q  <= S_ISSUE;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign s_ready    = s_ready_q;
   assign busy       = busy_q;
   assign enable     = enable_q;
   assign cmd        = cmd_q;
   assign in1        = in1_q;
   assign in2        = in2_q;
   assign m_valid    = m_valid_q;
   assign m_result   = m_result_q;
   assign m_timeout  = m_timeout_q;
   assign issued_cnt = issued_q;

endmodule
